// File: rtl/bitop_alu_pipe.sv
// Two-stage pipelined bit-manipulation ALU with valid/ready handshakes on both sides.
// Define BITOP_ALU_CLZ_EN to build the count-leading/trailing-zeros opcodes; otherwise they report as illegal.
module bitop_alu_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int SHW        = $clog2(DATA_WIDTH),
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Alu_out,
  output logic [TAG_W-1:0]      tag_out,
  output logic                  err_out
);

  logic                  s1_valid;
  logic                  s2_valid;
  logic [2:0]            s1_op;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [SHW-1:0]        s1_sh;
  logic [TAG_W-1:0]      s1_tag;
  logic                  s2_load;

  logic [DATA_WIDTH-1:0] result;
  logic                  res_err;
  logic [DATA_WIDTH-1:0] rot_r;
  logic [DATA_WIDTH-1:0] rot_l;
  logic [DATA_WIDTH-1:0] rev;
  logic [SHW:0]          pop;

  // Only the low SHW bits of B select the rotate amount.
  logic unused_b_hi;
  assign unused_b_hi = ^B_in[DATA_WIDTH-1:SHW];

  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_op  <= opcode;
      s1_a   <= A_in;
      s1_sh  <= B_in[SHW-1:0];
      s1_tag <= tag_in;
    end
  end

  // Output registers only change when a real operation moves into S2, so a stalled result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      Alu_out  <= '0;
      tag_out  <= '0;
      err_out  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Alu_out <= result;
        err_out <= res_err;
        tag_out <= s1_tag;
      end
    end
  end

  // A shift by the full width yields zero, so an amount of 0 falls through as A unchanged.
  assign rot_r = (s1_a >> s1_sh) | (s1_a << (DATA_WIDTH - s1_sh));
  assign rot_l = (s1_a << s1_sh) | (s1_a >> (DATA_WIDTH - s1_sh));

  always_comb begin
    pop = '0;
    rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop    = pop + (SHW+1)'(s1_a[i]);
      rev[i] = s1_a[DATA_WIDTH-1-i];
    end
  end

`ifdef BITOP_ALU_CLZ_EN
  logic [SHW:0] clz;
  logic [SHW:0] ctz;

  // Later hits overwrite earlier ones, leaving the most significant (clz) or least significant (ctz) one.
  always_comb begin
    clz = (SHW+1)'(DATA_WIDTH);
    ctz = (SHW+1)'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s1_a[i]) clz = (SHW+1)'(DATA_WIDTH - 1 - i);
    end
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (s1_a[i]) ctz = (SHW+1)'(i);
    end
  end
`endif

  always_comb begin
    result  = '0;
    res_err = 1'b0;
    case (s1_op)
      3'b000: result = {{(DATA_WIDTH-1){1'b0}}, ^s1_a};
      3'b001: result = rot_r;
      3'b010: result = rot_l;
      3'b011: result = {{(DATA_WIDTH-SHW-1){1'b0}}, pop};
      3'b100: result = rev;
`ifdef BITOP_ALU_CLZ_EN
      3'b101: result = {{(DATA_WIDTH-SHW-1){1'b0}}, clz};
      3'b110: result = {{(DATA_WIDTH-SHW-1){1'b0}}, ctz};
`endif
      default: res_err = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bitop_alu_pipe.sv
// Randomised and directed bench for bitop_alu_pipe at DATA_WIDTH=32, checked against a scoreboard
// fed by a behavioural model; honours BITOP_ALU_CLZ_EN the same way the design does.
module tb_bitop_alu_pipe;

  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [DW-1:0] A_in;
  logic [DW-1:0] B_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Alu_out;
  logic [TW-1:0] tag_out;
  logic          err_out;

  bitop_alu_pipe #(.DATA_WIDTH(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .A_in(A_in), .B_in(B_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .Alu_out(Alu_out), .tag_out(tag_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    logic [TW-1:0] tag;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            vectors;
  int            miscompares;
  int            cyc;
  int            accepted;
  int            delivered;
  int            lat_bad;
  logic          hold_prev;
  logic [DW-1:0] hold_alu;
  logic [TW-1:0] hold_tag;
  logic          hold_err;

  // Behavioural model: returns {err, result} straight from the operation definitions.
  function automatic logic [DW:0] refModel(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          e;
    int            s;
    int            n;
    r = '0;
    e = 1'b0;
    s = int'(b % DW);
    n = 0;
    case (op)
      3'd0: r = DW'($countones(a) % 2);
      3'd1: r = (a >> s) | (a << (DW - s));
      3'd2: r = (a << s) | (a >> (DW - s));
      3'd3: r = DW'($countones(a));
      3'd4: for (int i = 0; i < DW; i++) r[i] = a[DW-1-i];
`ifdef BITOP_ALU_CLZ_EN
      3'd5: begin
        while (n < DW && a[DW-1-n] == 1'b0) n++;
        r = DW'(n);
      end
      3'd6: begin
        while (n < DW && a[n] == 1'b0) n++;
        r = DW'(n);
      end
`endif
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and samples handshakes just before the rising edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [TW-1:0] tag,
                               input logic ordy);
    logic [DW:0] m;
    exp_t        e;
    in_valid  = v;
    opcode    = op;
    A_in      = a;
    B_in      = b;
    tag_in    = tag;
    out_ready = ordy;
    #4;
    if (hold_prev) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", {err_out, tag_out, Alu_out}, {hold_err, hold_tag, hold_alu});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("result", Alu_out, e.res);
        checkOutput("err", err_out, e.err);
        checkOutput("tag", tag_out, e.tag);
        if (cyc - e.acc_cyc != 2) lat_bad++;
        delivered++;
      end
    end
    if (in_valid && in_ready) begin
      m = refModel(opcode, A_in, B_in);
      e.res = m[DW-1:0];
      e.err = m[DW];
      e.tag = tag_in;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      accepted++;
    end
    hold_prev = out_valid && !out_ready;
    hold_alu  = Alu_out;
    hold_tag  = tag_out;
    hold_err  = err_out;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1);
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; accepted = 0; delivered = 0; lat_bad = 0;
    hold_prev = 1'b0; hold_alu = '0; hold_tag = '0; hold_err = 1'b0;
    in_valid = 1'b0; opcode = '0; A_in = '0; B_in = '0; tag_in = '0; out_ready = 1'b1;
    rst_n = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_alu", Alu_out, 0);
    checkOutput("rst_err", err_out, 0);
    checkOutput("rst_tag", tag_out, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);

    lat_bad = 0; delivered = 0;
    applyStimulus(1'b1, 3'd3, 32'hF0F0_0001, 32'd0, 4'h1, 1'b1);
    applyStimulus(1'b1, 3'd1, 32'h0000_0001, 32'd1, 4'h2, 1'b1);
    applyStimulus(1'b1, 3'd2, 32'h8000_0000, 32'd33, 4'h3, 1'b1);
    applyStimulus(1'b1, 3'd0, 32'h0000_0007, 32'd0, 4'h4, 1'b1);
    drain("b2b_drain");
    checkOutput("b2b_delivered", delivered, 4);
    checkOutput("b2b_latency", lat_bad, 0);

    accepted = 0; delivered = 0;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 3'($urandom_range(0, 4)), $urandom, $urandom, 4'(i + 8), 1'b0);
    checkOutput("bp_accepted", accepted, 2);
    checkOutput("bp_in_ready", in_ready, 0);
    drain("bp_drain");
    checkOutput("bp_delivered", delivered, 2);

    applyStimulus(1'b1, 3'd4, 32'h0000_0003, 32'd0, 4'h5, 1'b1);
    applyStimulus(1'b1, 3'd7, 32'h1234_5678, 32'd3, 4'hA, 1'b1);
    applyStimulus(1'b1, 3'd5, 32'h0001_0000, 32'd0, 4'h6, 1'b1);
    applyStimulus(1'b1, 3'd6, 32'h0001_0000, 32'd0, 4'h7, 1'b1);
    applyStimulus(1'b1, 3'd5, 32'h0000_0000, 32'd0, 4'h8, 1'b1);
    applyStimulus(1'b1, 3'd6, 32'h0000_0000, 32'd0, 4'h9, 1'b1);
    applyStimulus(1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0000_0020, 4'hB, 1'b1);
    drain("dir_drain");

    accepted = 0; delivered = 0;
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, 4'($urandom),
                    ($urandom_range(0, 3) != 0));
    drain("rand_drain");
    checkOutput("rand_count", delivered, accepted);

    applyStimulus(1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0, 4'hC, 1'b0);
    applyStimulus(1'b1, 3'd3, 32'h0000_00FF, 32'd0, 4'hD, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("midrst_out_valid", out_valid, 0);
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b1);
      checkOutput("midrst_idle", out_valid, 0);
    end
    lat_bad = 0; delivered = 0;
    applyStimulus(1'b1, 3'd2, 32'h0000_00F0, 32'd4, 4'hE, 1'b1);
    drain("midrst_drain");
    checkOutput("midrst_delivered", delivered, 1);
    checkOutput("midrst_latency", lat_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
